// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC access scheduler: FSM state encodings,
// RTC register map, hour-byte layout and burst index helpers.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_GAP,
        ST_EDIT
    } sched_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_GAP
    } txn_state_t;

    localparam logic [7:0] RTC_ADDR_SEC  = 8'h21;
    localparam logic [7:0] RTC_ADDR_MIN  = 8'h22;
    localparam logic [7:0] RTC_ADDR_HOUR = 8'h23;

    localparam int HOUR_FMT_BIT  = 7;
    localparam int HOUR_AMPM_BIT = 6;

    localparam logic [1:0] IDX_SEC  = 2'd0;
    localparam logic [1:0] IDX_MIN  = 2'd1;
    localparam logic [1:0] IDX_HOUR = 2'd2;

    // Register address for a burst index (sec, min, hour).
    function automatic logic [7:0] idx_addr(input logic [1:0] idx);
        case (idx)
            IDX_SEC: return RTC_ADDR_SEC;
            IDX_MIN: return RTC_ADDR_MIN;
            default: return RTC_ADDR_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_txn.sv
// Single RTC bus transaction engine: registers address/direction/data at
// issue, holds bus_req until bus_ack, then forces one idle GAP cycle.
// Optional ack timeout is enabled by defining RTC_SCHED_TIMEOUT_EN.
module rtc_bus_txn #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic       issue_we,
    input  logic [7:0] issue_addr,
    input  logic [7:0] issue_wdata,
    input  logic       bus_ack,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       done,
    output logic       timeout
);
    import rtc_pkg::*;

    txn_state_t tstate;

    // A transaction completes in the cycle its ack is seen.
    assign done = (tstate == TX_REQ) && bus_ack;

    // Request/ack handshake; a new issue is accepted from IDLE or the GAP cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tstate    <= TX_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
        end else begin
            case (tstate)
                TX_IDLE, TX_GAP: begin
                    if (issue) begin
                        bus_req   <= 1'b1;
                        bus_we    <= issue_we;
                        bus_addr  <= issue_addr;
                        bus_wdata <= issue_wdata;
                        tstate    <= TX_REQ;
                    end else begin
                        tstate <= TX_IDLE;
                    end
                end
                TX_REQ: begin
                    if (bus_ack || timeout) begin
                        bus_req <= 1'b0;
                        tstate  <= TX_GAP;
                    end
                end
                default: begin
                    bus_req <= 1'b0;
                    tstate  <= TX_IDLE;
                end
            endcase
        end
    end

`ifdef RTC_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;

    // Cycles spent with bus_req high; every transaction is separated by a low cycle.
    always_ff @(posedge clk) begin
        if (!reset || !bus_req) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Give up on the final allowed cycle so bus_req is high exactly TIMEOUT_CYCLES cycles.
    assign timeout = bus_req && !bus_ack && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/rtc_access_sched.sv
// RTC access scheduler: arbitrates periodic refresh read bursts and editor
// write-back bursts over one register-bus master, owns the displayed time
// snapshot and the editor enable. Ack timeout/err via RTC_SCHED_TIMEOUT_EN.
module rtc_access_sched #(
    parameter int REFRESH_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       edit_req,
    input  logic       commit,
    input  logic [7:0] HC,
    input  logic [7:0] MC,
    input  logic [7:0] SC,
    input  logic       AmPm,
    output logic       EN,
    output logic [7:0] H,
    output logic [7:0] M,
    output logic [7:0] S,
    output logic       ampm,
    output logic       format,
    output logic       busy,
    output logic       err,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata
);
    import rtc_pkg::*;

    localparam int CNT_W = $clog2(REFRESH_CYCLES);

    sched_state_t     state;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       idx;
    logic             burst_we;
    logic             boot;
    logic [5:0]       sh_sec;
    logic [5:0]       sh_min;

    logic             refresh_due;
    logic             issue;
    logic             issue_we;
    logic [1:0]       issue_idx;
    logic [7:0]       issue_addr;
    logic [7:0]       issue_wdata;
    logic             done;
    logic             timeout;
    logic             unused_edit_bits;

    // Write byte for a burst index; the hour byte keeps the 12/24 flag last read.
    function automatic logic [7:0] wr_byte(input logic [1:0] i, input logic [5:0] sec,
                                           input logic [5:0] min, input logic [4:0] hr,
                                           input logic ap, input logic fmt);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            IDX_SEC: b[5:0] = sec;
            IDX_MIN: b[5:0] = min;
            default: begin
                b[4:0]          = hr;
                b[HOUR_AMPM_BIT] = ap;
                b[HOUR_FMT_BIT]  = fmt;
            end
        endcase
        return b;
    endfunction

    assign refresh_due      = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));
    assign unused_edit_bits = ^{HC[7:5], MC[7:6], SC[7:6]};

    // Decide when the next transaction is launched and which register it targets.
    always_comb begin
        issue     = 1'b0;
        issue_we  = 1'b0;
        issue_idx = IDX_SEC;
        case (state)
            ST_IDLE: issue = boot || (!edit_req && refresh_due);
            ST_EDIT: begin
                issue    = commit;
                issue_we = commit;
            end
            ST_GAP: begin
                if (idx != IDX_HOUR) begin
                    issue     = 1'b1;
                    issue_we  = burst_we;
                    issue_idx = idx + 2'd1;
                end else begin
                    // A finished write burst is followed by a verify read from sec.
                    issue = burst_we;
                end
            end
            default: ;
        endcase
    end

    assign issue_addr  = idx_addr(issue_idx);
    assign issue_wdata = wr_byte(issue_idx, SC[5:0], MC[5:0], HC[4:0], AmPm, format);

    rtc_bus_txn #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_txn (
        .clk        (clk),
        .reset      (reset),
        .issue      (issue),
        .issue_we   (issue_we),
        .issue_addr (issue_addr),
        .issue_wdata(issue_wdata),
        .bus_ack    (bus_ack),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .done       (done),
        .timeout    (timeout)
    );

    // Burst sequencing, refresh timing, editor handshake and snapshot update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            refresh_cnt <= '0;
            idx         <= IDX_SEC;
            burst_we    <= 1'b0;
            boot        <= 1'b1;
            sh_sec      <= 6'd0;
            sh_min      <= 6'd0;
            EN          <= 1'b0;
            H           <= 8'h00;
            M           <= 8'h00;
            S           <= 8'h00;
            ampm        <= 1'b0;
            format      <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (boot || (!edit_req && refresh_due)) begin
                        boot        <= 1'b0;
                        state       <= ST_RD;
                        idx         <= IDX_SEC;
                        burst_we    <= 1'b0;
                        refresh_cnt <= '0;
                        busy        <= 1'b1;
                    end else if (edit_req) begin
                        state <= ST_EDIT;
                        EN    <= 1'b1;
                    end else begin
                        refresh_cnt <= refresh_cnt + 1'b1;
                    end
                end
                ST_EDIT: begin
                    if (commit) begin
                        EN       <= 1'b0;
                        state    <= ST_WR;
                        idx      <= IDX_SEC;
                        burst_we <= 1'b1;
                        busy     <= 1'b1;
                    end else if (!edit_req) begin
                        // Any refresh that fell due while editing is dropped.
                        EN          <= 1'b0;
                        state       <= ST_IDLE;
                        refresh_cnt <= '0;
                    end
                end
                ST_RD, ST_WR: begin
                    if (timeout) begin
                        state <= ST_IDLE;
                        idx   <= IDX_SEC;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (done) begin
                        state <= ST_GAP;
                        if (state == ST_RD) begin
                            case (idx)
                                IDX_SEC: sh_sec <= bus_rdata[5:0];
                                IDX_MIN: sh_min <= bus_rdata[5:0];
                                default: begin
                                    // Publish the whole snapshot at once on the hour ack.
                                    S      <= {2'b00, sh_sec};
                                    M      <= {2'b00, sh_min};
                                    H      <= {3'b000, bus_rdata[4:0]};
                                    ampm   <= bus_rdata[HOUR_AMPM_BIT];
                                    format <= bus_rdata[HOUR_FMT_BIT];
                                end
                            endcase
                        end
                    end
                end
                ST_GAP: begin
                    if (idx != IDX_HOUR) begin
                        idx   <= idx + 2'd1;
                        state <= burst_we ? ST_WR : ST_RD;
                    end else if (burst_we) begin
                        idx      <= IDX_SEC;
                        burst_we <= 1'b0;
                        state    <= ST_RD;
                    end else begin
                        idx  <= IDX_SEC;
                        busy <= 1'b0;
                        if (edit_req) begin
                            state <= ST_EDIT;
                            EN    <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rtc_access_sched.md
# rtc_access_sched

Scheduler for the single RTC register-bus master. Two requesters share that master: a periodic refresh reader that keeps the displayed time current, and the write-back of values edited in the time-setting editor. The block also enables the editor (`EN`) and owns the H/M/S/ampm/format snapshot the editor loads, sequencing each access as a 3-register burst (seconds, minutes, hours).

## Interface
Parameters:
- `REFRESH_CYCLES`, 1000000, clk cycles between refresh read bursts (≥16)
- `TIMEOUT_CYCLES`, 255, max cycles waiting for `bus_ack` (used only with the timeout macro)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `edit_req`  in  1  level; user requests edit mode
- `commit`  in  1  1-cycle pulse; write edited values to RTC
- `HC`, `MC`, `SC`  in  8 each  edited hour/min/sec (binary) from editor
- `AmPm`  in  1  edited am/pm from editor
- `EN`  out  1  editor enable
- `H`, `M`, `S`  out  8 each  last time read from RTC (binary)
- `ampm`, `format`  out  1 each  last am/pm and 12/24 flag read
- `busy`  out  1  burst in progress
- `err`  out  1  sticky bus timeout flag
- `bus_req`  out  1  transaction request, held until ack
- `bus_we`  out  1  1 = write, 0 = read
- `bus_addr`  out  8  RTC register address
- `bus_wdata`  out  8  write data
- `bus_ack`  in  1  transaction done (earliest: cycle after `bus_req` rises)
- `bus_rdata`  in  8  read data, valid with `bus_ack`

## Operation
- States: IDLE, RD, WR, GAP, EDIT. A 2-bit index selects sec(0), min(1), hour(2).
- Reset: state IDLE. Every output, the refresh counter, the index and the shadow registers are 0.
- Leaving reset triggers an immediate read burst.
- IDLE: the refresh counter increments. At `REFRESH_CYCLES-1` with `edit_req`=0 → RD at index 0, counter cleared. `edit_req`=1 → EDIT.
- RD/WR: `bus_req`=1; addr, we and wdata are stable until `bus_ack`.
  - On ack, RD captures into shadow: sec/min take `bus_rdata[5:0]`; hour takes [4:0], ampm bit6, format bit7.
  - On ack → GAP with `bus_req`=0 for one cycle. The index then advances and the block returns to RD/WR.
  - After index 2, a read burst copies shadow into H/M/S/ampm/format in one cycle, then goes to EDIT if `edit_req`=1, else IDLE.
  - After index 2, a write burst starts a verify read burst.
- Write data: sec/min = `{2'b0, xC[5:0]}`; hour = `{format, AmPm, 1'b0, HC[4:0]}`, where format is the last value read.
- EDIT: `EN`=1 and the refresh counter is held.
  - `commit` → `EN`=0, then a WR burst. Edited inputs are sampled when each WR transaction is issued.
  - `edit_req` falls without `commit` → `EN`=0, back to IDLE, no write.
- `commit` outside EDIT is ignored. A refresh due during EDIT is dropped; the counter restarts in IDLE.
- `edit_req` rising mid-read-burst: the burst completes, then EDIT, so the editor loads fresh values. `edit_req` falling mid-write-burst does not abort the burst.
- `busy`=1 in RD, WR and GAP.
- Reset asserted mid-burst: `bus_req` drops the next cycle and no partial shadow update reaches the outputs.

## Timing
- With ack latency L≥1, each transaction takes L+1 cycles plus the 1-cycle GAP.
- H/M/S/ampm/format update in the cycle after the hour ack (cycle 3(L+2)−1 from burst start), all together.
- `EN` rises in the cycle after entering EDIT and falls in the cycle after `commit` is sampled.
- All outputs are registered.

## Configuration
- `RTC_SCHED_TIMEOUT_EN` defined: a per-transaction counter runs while `bus_req`=1. At `TIMEOUT_CYCLES` with no ack:
  - `bus_req` drops and `err` is set (sticky until reset).
  - The burst is aborted to IDLE and outputs are not updated.
- `RTC_SCHED_TIMEOUT_EN` undefined: the block waits for ack indefinitely and `err` is tied 0.

## Structure
- Shared package `rtc_pkg`:
  - state enum
  - register address constants `RTC_ADDR_SEC`=8'h21, `RTC_ADDR_MIN`=8'h22, `RTC_ADDR_HOUR`=8'h23
  - hour-byte bit positions (format 7, ampm 6)
- One natural sub-module: `rtc_bus_txn`, which does single-transaction req/ack handling, GAP and the timeout counter. The scheduler FSM drives it with index, we and data.

## Test plan
- Reset release with bus ack latency 1 and RTC holding sec=0x2A, min=0x0F, hour=0x4B → burst issues addresses 21, 22, 23; outputs become S=42, M=15, H=11, ampm=1, format=0 at cycle 8; `busy` is low from cycle 9.
- `edit_req`=1 while idle → `EN`=1 and no reads. Hold 3×`REFRESH_CYCLES`, then pulse `commit` with HC=7, MC=30, SC=0, AmPm=1 → writes 0x00, 0x1E, 0x47, followed by a verify read.
- `edit_req` rises during a read burst at index 1 → burst completes, outputs update, `EN` rises the next cycle.
- `edit_req` falls without `commit` → no `bus_we`, back to IDLE; the next refresh comes after `REFRESH_CYCLES`.
- `bus_ack` never asserted with the macro defined → `bus_req` drops after 255 cycles, `err`=1, outputs unchanged. With the macro undefined, `bus_req` stays high.
- Reset asserted at index 1 of a write burst → `bus_req`=0 the next cycle, all outputs 0, and a fresh read burst starts after release.
